// File: rtl/encrypt_stream_unit.sv
// Streaming rotate/XOR cipher with a programmable key bank, rotating key schedule
// and a two-stage valid/ready pipeline (key snapshot in stage 1, transform in stage 2).
module encrypt_stream_unit #(
   parameter int DW       = 8,
   parameter int NKEYS    = 3,
   parameter int PERM_ROT = 1,
   localparam int KIW     = $clog2(NKEYS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  din,
   input  logic           mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  dout,
   input  logic           key_wr,
   input  logic [KIW-1:0] key_idx,
   input  logic [DW-1:0]  key_data,
   input  logic [2:0]     rot_freq,
   input  logic           seq_clr,
   output logic [KIW-1:0] key_ptr
);

   localparam logic [KIW:0]   NKEYS_W  = (KIW+1)'(NKEYS);
   localparam logic [KIW-1:0] LAST_PTR = KIW'(NKEYS - 1);

   logic [DW-1:0]  bank [NKEYS];
   logic [2:0]     beat_cnt;

   logic           s1_valid;
   logic [DW-1:0]  s1_data;
   logic           s1_mode;
   logic [DW-1:0]  s1_key;

   logic           s2_ready;
   logic           s1_ready;
   logic           accept;
   logic           s1_move;

   logic [KIW-1:0] base_ptr;
   logic [2:0]     base_cnt;
   logic [KIW-1:0] nxt_ptr;
   logic [2:0]     nxt_cnt;

   function automatic logic [DW-1:0] transform(input logic [DW-1:0] d,
                                               input logic [DW-1:0] k,
                                               input logic          dec);
      logic [DW-1:0] t;
      if (dec) begin
         t = d ^ k;
         return {t[PERM_ROT-1:0], t[DW-1:PERM_ROT]};
      end
      return {d[DW-1-PERM_ROT:0], d[DW-1:DW-PERM_ROT]} ^ k;
   endfunction

   assign s2_ready = !out_valid || out_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready;
   assign accept   = in_valid && in_ready;
   assign s1_move  = s1_valid && s2_ready;

   // seq_clr restarts the schedule first, so a beat accepted alongside it
   // takes bank[0] and counts as beat one of the new sequence.
   always_comb begin
      base_ptr = seq_clr ? '0 : key_ptr;
      base_cnt = seq_clr ? '0 : beat_cnt;
      nxt_ptr  = base_ptr;
      nxt_cnt  = base_cnt;
      if (accept) begin
         if (rot_freq == 3'd0) begin
            nxt_ptr = '0;
         end else if (({1'b0, base_cnt} + 4'd1) >= {1'b0, rot_freq}) begin
            nxt_cnt = '0;
            nxt_ptr = (base_ptr == LAST_PTR) ? '0 : base_ptr + 1'b1;
         end else begin
            nxt_cnt = base_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_ptr  <= '0;
         beat_cnt <= '0;
      end else begin
         key_ptr  <= nxt_ptr;
         beat_cnt <= nxt_cnt;
      end
   end

   // Writes land at the edge, so a same-cycle accept still snapshots the old key.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NKEYS; i++) bank[i] <= '0;
      end else if (key_wr && ({1'b0, key_idx} < NKEYS_W)) begin
         bank[key_idx] <= key_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= 1'b0;
         s1_key   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_data  <= din;
         s1_mode  <= mode;
         s1_key   <= bank[base_ptr];
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
      end else if (s1_move) begin
         out_valid <= 1'b1;
         dout      <= transform(s1_data, s1_key, s1_mode);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_encrypt_stream_unit.sv
// Directed cycle-by-cycle vectors for encrypt_stream_unit (DW=8, NKEYS=3, PERM_ROT=1)
// with hand-computed outputs; reset-while-full is exercised as a separate sequence.
module tb_encrypt_stream_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din;
   logic       mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic       key_wr;
   logic [1:0] key_idx;
   logic [7:0] key_data;
   logic [2:0] rot_freq;
   logic       seq_clr;
   logic [1:0] key_ptr;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic       in_valid;
      logic [7:0] din;
      logic       mode;
      logic       out_ready;
      logic       seq_clr;
      logic [2:0] rot_freq;
      logic       key_wr;
      logic [1:0] key_idx;
      logic [7:0] key_data;
      logic       exp_valid;
      logic [7:0] exp_dout;
      logic [1:0] exp_ptr;
      logic       exp_ready;
   } vec_t;

   vec_t vecs[$];

   encrypt_stream_unit #(.DW(8), .NKEYS(3), .PERM_ROT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .key_wr    (key_wr),
      .key_idx   (key_idx),
      .key_data  (key_data),
      .rot_freq  (rot_freq),
      .seq_clr   (seq_clr),
      .key_ptr   (key_ptr)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic m,
                               input logic orr, input logic sc, input logic [2:0] rf,
                               input logic kw, input logic [1:0] ki, input logic [7:0] kd,
                               input logic ev, input logic [7:0] ed, input logic [1:0] ep,
                               input logic er);
      vec_t v;
      v.in_valid = iv;  v.din = d;        v.mode = m;       v.out_ready = orr;
      v.seq_clr = sc;   v.rot_freq = rf;  v.key_wr = kw;    v.key_idx = ki;
      v.key_data = kd;  v.exp_valid = ev; v.exp_dout = ed;  v.exp_ptr = ep;
      v.exp_ready = er;
      return v;
   endfunction

   // Plain beat (or idle when iv=0) with out_ready high, no clear, no key write.
   function automatic vec_t bt(input logic iv, input logic [7:0] d, input logic m,
                               input logic [2:0] rf, input logic ev, input logic [7:0] ed,
                               input logic [1:0] ep);
      return mk(iv, d, m, 1'b1, 1'b0, rf, 1'b0, 2'd0, 8'h00, ev, ed, ep, 1'b1);
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      in_valid  = v.in_valid;
      din       = v.din;
      mode      = v.mode;
      out_ready = v.out_ready;
      seq_clr   = v.seq_clr;
      rot_freq  = v.rot_freq;
      key_wr    = v.key_wr;
      key_idx   = v.key_idx;
      key_data  = v.key_data;
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d out_valid", idx), {7'd0, out_valid}, {7'd0, v.exp_valid});
      if (v.exp_valid)
         checkOutput($sformatf("row%0d dout", idx), dout, v.exp_dout);
      checkOutput($sformatf("row%0d key_ptr", idx), {6'd0, key_ptr}, {6'd0, v.exp_ptr});
      checkOutput($sformatf("row%0d in_ready", idx), {7'd0, in_ready}, {7'd0, v.exp_ready});
   endtask

   task automatic writeKey(input logic [1:0] idx, input logic [7:0] data);
      key_wr   = 1'b1;
      key_idx  = idx;
      key_data = data;
      @(posedge clk);
      #1;
      key_wr   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din = '0; mode = 1'b0; out_ready = 1'b1;
      key_wr = 1'b0; key_idx = '0; key_data = '0; rot_freq = 3'd1; seq_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("reset dout", dout, 8'h00);
      checkOutput("reset key_ptr", {6'd0, key_ptr}, 8'd0);
      checkOutput("reset in_ready", {7'd0, in_ready}, 8'd1);
      rst = 1'b0;

      writeKey(2'd0, 8'h3C);
      writeKey(2'd1, 8'hA5);
      writeKey(2'd2, 8'h0F);
      writeKey(2'd3, 8'hFF);

      // Encrypt, rot_freq=1: keys K0,K1,K2,K0.
      vecs.push_back(bt(1, 8'h81, 0, 3'd1, 0, 8'h00, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd1, 1, 8'h3F, 2'd2));
      vecs.push_back(bt(1, 8'h81, 0, 3'd1, 1, 8'hA6, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd1, 1, 8'h0C, 2'd1));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 0, 8'h00, 2'd1));
      // Decrypt round trip after a bare seq_clr.
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 3'd1, 0, 2'd0, 8'h00, 0, 8'h00, 2'd0, 1));
      vecs.push_back(bt(1, 8'h3F, 1, 3'd1, 0, 8'h00, 2'd1));
      vecs.push_back(bt(1, 8'hA6, 1, 3'd1, 1, 8'h81, 2'd2));
      vecs.push_back(bt(1, 8'h0C, 1, 3'd1, 1, 8'h81, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 1, 8'h81, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 0, 8'h00, 2'd0));
      // rot_freq=2: K0,K0,K1,K1,K2,K2,K0.
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 3'd2, 0, 2'd0, 8'h00, 0, 8'h00, 2'd0, 1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 0, 8'h00, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'hA6, 2'd2));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'hA6, 2'd2));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h0C, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h0C, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd2, 1, 8'h3F, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd2, 0, 8'h00, 2'd0));
      // rot_freq=0: always K0, pointer pinned.
      vecs.push_back(bt(1, 8'h81, 0, 3'd0, 0, 8'h00, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd0, 1, 8'h3F, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd0, 1, 8'h3F, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd0, 1, 8'h3F, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd0, 0, 8'h00, 2'd0));
      // Backpressure: 5 stalled cycles, only two beats get in.
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 3'd1, 0, 2'd0, 8'h00, 0, 8'h00, 2'd0, 1));
      vecs.push_back(mk(1, 8'h01, 0, 0, 0, 3'd1, 0, 2'd0, 8'h00, 0, 8'h00, 2'd1, 1));
      vecs.push_back(mk(1, 8'h02, 0, 0, 0, 3'd1, 0, 2'd0, 8'h00, 1, 8'h3E, 2'd2, 0));
      vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3'd1, 0, 2'd0, 8'h00, 1, 8'h3E, 2'd2, 0));
      vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3'd1, 0, 2'd0, 8'h00, 1, 8'h3E, 2'd2, 0));
      vecs.push_back(mk(1, 8'h03, 0, 0, 0, 3'd1, 0, 2'd0, 8'h00, 1, 8'h3E, 2'd2, 0));
      vecs.push_back(bt(1, 8'h03, 0, 3'd1, 1, 8'hA1, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 1, 8'h09, 2'd0));
      vecs.push_back(bt(0, 8'h00, 0, 3'd1, 0, 8'h00, 2'd0));
      // seq_clr + accept + key write to bank[0] while key_ptr=2, rot_freq=2.
      vecs.push_back(mk(0, 8'h00, 0, 1, 1, 3'd2, 0, 2'd0, 8'h00, 0, 8'h00, 2'd0, 1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 0, 8'h00, 2'd0));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'hA6, 2'd2));
      vecs.push_back(mk(1, 8'h81, 0, 1, 1, 3'd2, 1, 2'd0, 8'h55, 1, 8'hA6, 2'd0, 1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h3F, 2'd1));
      vecs.push_back(bt(1, 8'h81, 0, 3'd2, 1, 8'h56, 2'd1));
      vecs.push_back(bt(0, 8'h00, 0, 3'd2, 1, 8'hA6, 2'd1));
      vecs.push_back(bt(0, 8'h00, 0, 3'd2, 0, 8'h00, 2'd1));

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Reset with both stages full.
      seq_clr = 1'b0; rot_freq = 3'd1; mode = 1'b0; din = 8'h81;
      in_valid = 1'b1; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("full in_ready", {7'd0, in_ready}, 8'd0);
      checkOutput("full out_valid", {7'd0, out_valid}, 8'd1);
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("midrst dout", dout, 8'h00);
      checkOutput("midrst key_ptr", {6'd0, key_ptr}, 8'd0);
      checkOutput("midrst in_ready", {7'd0, in_ready}, 8'd1);
      out_ready = 1'b1; in_valid = 1'b1; din = 8'h81;
      @(posedge clk);
      #1;
      din = 8'h40;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("postrst dout0", dout, 8'h03);
      checkOutput("postrst valid0", {7'd0, out_valid}, 8'd1);
      @(posedge clk);
      #1;
      checkOutput("postrst dout1", dout, 8'h80);
      checkOutput("postrst key_ptr", {6'd0, key_ptr}, 8'd2);
      @(posedge clk);
      #1;
      checkOutput("postrst drained", {7'd0, out_valid}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/encrypt_stream_unit.md
Name: encrypt_stream_unit

Overview:
Parametrised successor of the fixed 8-bit encryption unit. It streams DW-bit words through a bit-rotate permutation and an XOR with a key taken from a programmable bank of NKEYS keys. The key rotates every rot_freq accepted beats. It supports per-beat encrypt or decrypt and full valid/ready backpressure through a 2-stage pipeline. It sits between the byte/word source and the link framer.

Parameters:
DW, 8, data and key width in bits (>=2)
NKEYS, 3, number of keys in the bank (>=2); KIW = $clog2(NKEYS) is derived locally
PERM_ROT, 1, left-rotate amount of the permutation (0 < PERM_ROT < DW)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  unit can accept the input word
din  in  DW  input word
mode  in  1  per-beat select: 0 = encrypt, 1 = decrypt; sampled with din
out_valid  out  1  dout valid
out_ready  in  1  downstream accepts dout
dout  out  DW  transformed word
key_wr  in  1  write key_data into key bank[key_idx]
key_idx  in  KIW  key bank index; values >= NKEYS are ignored (no write)
key_data  in  DW  key value
rot_freq  in  3  accepted beats per key; 0 = never rotate (always bank[0])
seq_clr  in  1  pulse: restart the key sequence
key_ptr  out  KIW  index of the key that the next accepted beat will use

Behaviour:
- Reset (rst=1 at a clk edge): key bank cleared to 0; key_ptr=0; beat counter=0; s1_valid=0; out_valid=0; dout=0; in_ready=1 in the following cycle.
- Handshake: a beat is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready. Once out_valid is high, dout is held stable until consumed.
- Ready chain (combinational):
  - s2_ready = !out_valid | out_ready
  - s1_ready = !s1_valid | s2_ready
  - in_ready = s1_ready
  - in_ready never depends on in_valid.
- Stage 1: on accept, register din, mode and bank[key_ptr] (key snapshot) and set s1_valid. s1_valid clears when s1 moves and there is no new accept.
- Stage 2: when s1_valid & s2_ready, compute and load dout, and set out_valid. out_valid clears on consume with no new load.
- Transform:
  - Encrypt: dout = rotl(din, PERM_ROT) ^ key.
  - Decrypt: dout = rotr(din ^ key, PERM_ROT). Decrypt is the exact inverse of encrypt.
- Latency: a beat accepted at edge N is visible on dout/out_valid after edge N+1, provided out_ready is high.
- Throughput: 1 word/clk with out_ready held high. Under a stall, both stages fill; in_ready falls in the cycle after the second word is held.
- Key rotation, evaluated on each accept:
  - If rot_freq=0: no change; key_ptr forced to 0.
  - Else if beat_cnt+1 >= rot_freq: beat_cnt := 0 and key_ptr := (key_ptr == NKEYS-1) ? 0 : key_ptr+1.
  - Else: beat_cnt := beat_cnt+1.
  - A change to rot_freq mid-stream takes effect on the next accept, using the >= compare (no lock-up).
- seq_clr has priority over rotation:
  - key_ptr := 0 and beat_cnt := 0.
  - A beat accepted in the same cycle uses bank[0] and is counted as the first beat (beat_cnt := 1, or pointer advance if rot_freq=1).
  - seq_clr does not flush the pipeline.
- Key write: takes effect at the edge. A beat accepted in the same cycle as a write to the current key_ptr uses the old value; beats already in the pipeline keep their snapshot.
- Stalls: a stall never changes key_ptr or beat_cnt; only accepts advance them.
- rst mid-stream: in-flight beats are discarded and the key bank is lost.

Test Plan:
- Encrypt, DW=8, PERM_ROT=1, keys 0x3C/0xA5/0x0F, rot_freq=1: four beats of din=0x81 with out_ready=1 -> dout 0x3F, 0xA6, 0x0C, 0x3F back-to-back, each 2 edges after accept; key_ptr goes 0,1,2,0.
- Decrypt round trip, same keys, rot_freq=1, seq_clr, then mode=1 beats 0x3F, 0xA6, 0x0C -> dout 0x81 ×3.
- rot_freq=2: seven beats of 0x81 -> keys used K0,K0,K1,K1,K2,K2,K0 -> dout 0x3F,0x3F,0xA6,0xA6,0x0C,0x0C,0x3F. rot_freq=0 -> all 0x3F and key_ptr stays 0.
- Backpressure: out_ready=0 for 5 cycles with in_valid held -> exactly 2 beats accepted, in_ready=0, dout stable. Releasing out_ready -> output order preserved, no loss or duplication, key_ptr advanced only by accepts.
- seq_clr together with an accept while key_ptr=2, rot_freq=2 -> that beat uses K0; the next beat uses K0, the following one K1. A key_wr to bank[0] in the same cycle -> that beat uses the old K0.
- Reset mid-stream with both stages full -> out_valid=0, dout=0, key_ptr=0 after the edge; subsequent encrypts use key 0x00 (dout 0x03 for 0x81).
